// File: rtl/gb_lcd_capture.sv
// Packs the gameboy LCD 2bpp pixel stream into bytes, four pixels per byte, and
// writes them to a linear framebuffer while tracking line/frame boundaries.
module gb_lcd_capture #(
    parameter int H_PIXELS = 160,
    parameter int V_LINES  = 144,
    parameter int ADDR_W   = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_en,
    input  logic              err_clr,
    input  logic              hs,
    input  logic              vs,
    input  logic              cpl,
    input  logic [1:0]        pixel,
    input  logic              valid,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_data,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              busy,
    output logic              err
);
    localparam int XW = $clog2(H_PIXELS + 1);
    localparam int YW = $clog2(V_LINES + 1);
    localparam logic [XW-1:0]     X_MAX      = XW'(H_PIXELS);
    localparam logic [XW-1:0]     X_ONE      = XW'(1);
    localparam logic [XW-1:0]     X_ZERO     = XW'(0);
    localparam logic [YW-1:0]     Y_MAX      = YW'(V_LINES);
    localparam logic [YW-1:0]     Y_ONE      = YW'(1);
    localparam logic [YW-1:0]     Y_ZERO     = YW'(0);
    localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(H_PIXELS / 4);
    localparam logic [ADDR_W-1:0] A_ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_ZERO     = ADDR_W'(0);

    typedef enum logic [0:0] {ST_WAIT_VS = 1'b0, ST_CAPTURE = 1'b1} state_t;

    // Pixel k of a byte lands in bits [7-2k:6-2k].
    function automatic logic [7:0] place_pixel(input logic [1:0] pix, input logic [1:0] pos);
        case (pos)
            2'd0:    place_pixel = {pix, 6'b000000};
            2'd1:    place_pixel = {2'b00, pix, 4'b0000};
            2'd2:    place_pixel = {4'b0000, pix, 2'b00};
            default: place_pixel = {6'b000000, pix};
        endcase
    endfunction

    state_t              state_q, state_d;
    logic                cpl_q, vs_q, hs_q;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic [1:0]          slot_q, slot_d;
    logic [7:0]          shift_q, shift_d;
    logic [ADDR_W-1:0]   line_base_q, line_base_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                fb_we_q, fb_we_d;
    logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
    logic [7:0]          fb_data_q, fb_data_d;
    logic                frame_done_q, frame_done_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic                err_q, err_d;
    logic                err_set_s, last_line_s, busy_s;
    logic [7:0]          byte_s;
    logic                pix_evt_s, vs_fall_s, hs_fall_s;

    assign pix_evt_s = cpl & ~cpl_q & valid;
    assign vs_fall_s = ~vs & vs_q;
    assign hs_fall_s = ~hs & hs_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_WAIT_VS;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; vs restarts override line/frame completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_VS: begin
                if (vs_fall_s && cap_en) state_d = ST_CAPTURE;
                else                     state_d = ST_WAIT_VS;
            end
            ST_CAPTURE: begin
                if (vs_fall_s)        state_d = cap_en ? ST_CAPTURE : ST_WAIT_VS;
                else if (last_line_s) state_d = ST_WAIT_VS;
                else                  state_d = ST_CAPTURE;
            end
            default: state_d = ST_WAIT_VS;
        endcase
    end

    // Output decode.
    always_comb begin
        busy_s = (state_q == ST_CAPTURE);
    end

    // Datapath next values: pixel is processed before a coincident line end.
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        slot_d       = slot_q;
        shift_d      = shift_q;
        line_base_d  = line_base_q;
        ptr_d        = ptr_q;
        fb_we_d      = 1'b0;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        err_set_s    = 1'b0;
        last_line_s  = 1'b0;
        byte_s       = shift_q | place_pixel(pixel, slot_q);
        if (vs_fall_s) begin
            err_set_s   = (state_q == ST_CAPTURE) && ((y_q != Y_ZERO) || (x_q != X_ZERO));
            x_d         = X_ZERO;
            y_d         = Y_ZERO;
            slot_d      = 2'd0;
            shift_d     = 8'h00;
            line_base_d = A_ZERO;
            ptr_d       = A_ZERO;
        end else if (state_q == ST_CAPTURE) begin
            if (pix_evt_s && (x_q == X_MAX)) begin
                err_set_s = 1'b1;
            end else if (pix_evt_s) begin
                x_d    = x_q + X_ONE;
                slot_d = slot_q + 2'd1;
                if (slot_q == 2'd3) begin
                    fb_we_d   = 1'b1;
                    fb_data_d = byte_s;
                    fb_addr_d = ptr_q;
                    ptr_d     = ptr_q + A_ONE;
                    shift_d   = 8'h00;
                end else begin
                    shift_d = byte_s;
                end
            end else begin
                shift_d = shift_q;
            end
            if (hs_fall_s && (x_d != X_ZERO)) begin
                err_set_s = err_set_s | (x_d != X_MAX);
                if (slot_d != 2'd0) begin
                    fb_we_d   = 1'b1;
                    fb_data_d = shift_d;
                    fb_addr_d = ptr_q;
                end else begin
                    fb_we_d = fb_we_d;
                end
                y_d         = y_q + Y_ONE;
                x_d         = X_ZERO;
                slot_d      = 2'd0;
                shift_d     = 8'h00;
                line_base_d = line_base_q + LINE_BYTES;
                ptr_d       = line_base_d;
                if (y_d == Y_MAX) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 8'd1;
                    last_line_s  = 1'b1;
                end else begin
                    last_line_s = 1'b0;
                end
            end else begin
                last_line_s = 1'b0;
            end
        end else begin
            err_set_s = 1'b0;
        end
        if (err_set_s)    err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
        else              err_d = err_q;
    end

    // Edge-detect history, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpl_q        <= 1'b0;
            vs_q         <= 1'b1;
            hs_q         <= 1'b1;
            x_q          <= X_ZERO;
            y_q          <= Y_ZERO;
            slot_q       <= 2'd0;
            shift_q      <= 8'h00;
            line_base_q  <= A_ZERO;
            ptr_q        <= A_ZERO;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= A_ZERO;
            fb_data_q    <= 8'h00;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'h00;
            err_q        <= 1'b0;
        end else begin
            cpl_q        <= cpl;
            vs_q         <= vs;
            hs_q         <= hs;
            x_q          <= x_d;
            y_q          <= y_d;
            slot_q       <= slot_d;
            shift_q      <= shift_d;
            line_base_q  <= line_base_d;
            ptr_q        <= ptr_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            err_q        <= err_d;
        end
    end

    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign busy       = busy_s;
    assign err        = err_q;
endmodule

// File: tb/tb_gb_lcd_capture.sv
// Directed bench for gb_lcd_capture: drives LCD sync/pixel sequences and checks
// framebuffer writes, frame counting and error flagging against hand-computed values.
module tb_gb_lcd_capture;
    localparam int ADDR_W = 13;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cap_en = 1'b0;
    logic              err_clr = 1'b0;
    logic              hs = 1'b1;
    logic              vs = 1'b1;
    logic              cpl = 1'b0;
    logic [1:0]        pixel = 2'b00;
    logic              valid = 1'b0;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [7:0]        fb_data;
    logic              frame_done;
    logic [7:0]        frame_cnt;
    logic              busy;
    logic              err;

    always #5 clk = ~clk;

    gb_lcd_capture #(.H_PIXELS(160), .V_LINES(144), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .cap_en(cap_en), .err_clr(err_clr),
        .hs(hs), .vs(vs), .cpl(cpl), .pixel(pixel), .valid(valid),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy), .err(err)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [0:8191];
    int         wr_cnt, addr_bad, fd_cnt, next_addr, max_addr, last_addr;
    logic [7:0] last_data;

    // Write logger, sampled mid-cycle.
    always @(negedge clk) begin
        if (fb_we === 1'b1) begin
            mem[fb_addr] = fb_data;
            wr_cnt = wr_cnt + 1;
            if (int'(fb_addr) != next_addr) addr_bad = addr_bad + 1;
            next_addr = int'(fb_addr) + 1;
            if (int'(fb_addr) > max_addr) max_addr = int'(fb_addr);
            last_addr = int'(fb_addr);
            last_data = fb_data;
        end
        if (frame_done === 1'b1) fd_cnt = fd_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        wr_cnt = 0; addr_bad = 0; fd_cnt = 0; next_addr = 0;
        max_addr = -1; last_addr = -1; last_data = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input logic [1:0] p);
        pixel = p; valid = 1'b1; cpl = 1'b1;
        tick();
        cpl = 1'b0;
        tick();
    endtask

    task automatic hs_pulse();
        hs = 1'b0; tick(); hs = 1'b1; tick();
    endtask

    task automatic vs_pulse();
        vs = 1'b0; tick(); vs = 1'b1; tick();
    endtask

    task automatic send_line(input int n, input logic [1:0] p);
        for (int i = 0; i < n; i++) send_pixel(p);
        hs_pulse();
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
    endtask

    int bad;

    initial begin
        clear_log();
        tick(); tick();
        check_eq("rst_fb_we", 32'(fb_we), 32'd0);
        check_eq("rst_fb_addr", 32'(fb_addr), 32'd0);
        check_eq("rst_fb_data", 32'(fb_data), 32'd0);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        check_eq("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        tick();

        // Reset at line 70, then nothing until the next vs.
        cap_en = 1'b1;
        vs_pulse();
        for (int l = 0; l < 70; l++) send_line(160, 2'b01);
        check_eq("midframe_busy", 32'(busy), 32'd1);
        check_eq("midframe_addr", 32'(fb_addr), 32'd2799);
        rst = 1'b0;
        #1;
        check_eq("rst70_fb_addr", 32'(fb_addr), 32'd0);
        check_eq("rst70_fb_data", 32'(fb_data), 32'd0);
        check_eq("rst70_busy", 32'(busy), 32'd0);
        check_eq("rst70_fb_we", 32'(fb_we), 32'd0);
        tick();
        rst = 1'b1;
        clear_log();
        send_line(160, 2'b01);
        send_line(160, 2'b01);
        check_eq("post_rst_no_write", 32'(wr_cnt), 32'd0);
        check_eq("post_rst_busy", 32'(busy), 32'd0);

        // Full clean frame of 2'b10 pixels.
        clear_log();
        vs_pulse();
        for (int l = 0; l < 144; l++) send_line(160, 2'b10);
        bad = 0;
        for (int i = 0; i < 5760; i++) if (mem[i] !== 8'hAA) bad = bad + 1;
        check_eq("full_writes", 32'(wr_cnt), 32'd5760);
        check_eq("full_data_bad", 32'(bad), 32'd0);
        check_eq("full_addr_gaps", 32'(addr_bad), 32'd0);
        check_eq("full_max_addr", 32'(max_addr), 32'd5759);
        check_eq("full_frame_done", 32'(fd_cnt), 32'd1);
        check_eq("full_frame_cnt", 32'(frame_cnt), 32'd1);
        check_eq("full_err", 32'(err), 32'd0);
        check_eq("full_busy", 32'(busy), 32'd0);

        // Pixels 3,2,1,0 -> 8'hE4 at addr 0, one clock after the 4th edge.
        clear_log();
        vs_pulse();
        send_pixel(2'b11); send_pixel(2'b10); send_pixel(2'b01);
        check_eq("lat_we_early", 32'(fb_we), 32'd0);
        pixel = 2'b00; cpl = 1'b1;
        tick();
        check_eq("lat_we", 32'(fb_we), 32'd1);
        check_eq("lat_data", 32'(fb_data), 32'hE4);
        check_eq("lat_addr", 32'(fb_addr), 32'd0);
        cpl = 1'b0;
        tick();
        check_eq("lat_we_one_cycle", 32'(fb_we), 32'd0);
        for (int i = 0; i < 156; i++) send_pixel(2'b00);
        hs_pulse();
        check_eq("clean_line_err", 32'(err), 32'd0);
        vs_pulse();
        check_eq("restart_err", 32'(err), 32'd1);
        check_eq("restart_busy", 32'(busy), 32'd1);
        pulse_err_clr();
        check_eq("restart_err_clr", 32'(err), 32'd0);

        // Short line of 158 pixels of 2'b11.
        clear_log();
        for (int i = 0; i < 158; i++) send_pixel(2'b11);
        hs_pulse();
        check_eq("short_writes", 32'(wr_cnt), 32'd40);
        check_eq("short_addr38", 32'(mem[38]), 32'hFF);
        check_eq("short_addr39", 32'(mem[39]), 32'hF0);
        check_eq("short_err", 32'(err), 32'd1);
        for (int i = 0; i < 4; i++) send_pixel(2'b01);
        check_eq("line1_addr", 32'(last_addr), 32'd40);
        check_eq("line1_data", 32'(last_data), 32'h55);
        pulse_err_clr();
        check_eq("short_err_clr", 32'(err), 32'd0);

        // valid=0, held cpl, and a 161st pixel.
        vs_pulse();
        pulse_err_clr();
        clear_log();
        valid = 1'b0; pixel = 2'b11; cpl = 1'b1;
        tick();
        valid = 1'b1;
        tick(); tick();
        cpl = 1'b0;
        tick();
        for (int i = 0; i < 160; i++) send_pixel(2'b01);
        check_eq("qual_writes", 32'(wr_cnt), 32'd40);
        check_eq("qual_first", 32'(mem[0]), 32'h55);
        check_eq("qual_max_addr", 32'(max_addr), 32'd39);
        check_eq("qual_err", 32'(err), 32'd0);
        send_pixel(2'b11);
        check_eq("drop_err", 32'(err), 32'd1);
        check_eq("drop_writes", 32'(wr_cnt), 32'd40);
        check_eq("drop_max_addr", 32'(max_addr), 32'd39);

        // cap_en=0 at vs: no capture, then resume at addr 0.
        clear_log();
        cap_en = 1'b0;
        vs_pulse();
        check_eq("noen_busy", 32'(busy), 32'd0);
        for (int l = 0; l < 3; l++) send_line(160, 2'b10);
        check_eq("noen_writes", 32'(wr_cnt), 32'd0);
        check_eq("noen_busy_after", 32'(busy), 32'd0);
        cap_en = 1'b1;
        vs_pulse();
        check_eq("resume_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) send_pixel(2'b10);
        check_eq("resume_writes", 32'(wr_cnt), 32'd1);
        check_eq("resume_addr", 32'(last_addr), 32'd0);
        check_eq("resume_data", 32'(last_data), 32'hAA);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/gb_lcd_capture.md
Name: gb_lcd_capture

Overview:
- Sits directly downstream of the gameboy core's LCD output (hs, vs, cpl, pixel, valid).
- Converts the 2bpp pixel stream into packed bytes, four pixels per byte, and writes them to a linear framebuffer RAM through a single write port.
- The framebuffer is then scanned out by the host display path.
- Tracks frame and line boundaries, reports frame completion, and flags malformed lines.

Parameters:
H_PIXELS, 160, active pixels per line; must be a multiple of 4
V_LINES, 144, active lines per frame
ADDR_W, 13, framebuffer byte address width; 2^ADDR_W must be >= H_PIXELS*V_LINES/4

Ports:
clk  input  1  core clock, same clock as the gameboy core
rst  input  1  asynchronous active-low reset
cap_en  input  1  capture enable; sampled only at frame start
err_clr  input  1  synchronous clear of err
hs  input  1  horizontal sync, active low
vs  input  1  vertical sync, active low
cpl  input  1  pixel latch strobe, clk-synchronous level; a pixel is taken on its rising edge
pixel  input  2  pixel data
valid  input  1  pixel qualifier
fb_we  output  1  framebuffer write strobe, one cycle per byte
fb_addr  output  ADDR_W  framebuffer byte address
fb_data  output  8  packed pixels; pixel k of the group occupies bits [7-2k:6-2k]
frame_done  output  1  one-cycle pulse after the last byte of a frame
frame_cnt  output  8  completed frames, wraps 255->0
busy  output  1  high in CAPTURE
err  output  1  sticky malformed-line/frame flag

Behaviour:
- Reset (rst=0, async): all outputs 0. State WAIT_VS. cpl_d=0, vs_d=1, hs_d=1.
- Edge detect:
  - pix_evt = cpl & ~cpl_d & valid.
  - vs_fall = ~vs & vs_d.
  - hs_fall = ~hs & hs_d.
  - cpl_d, vs_d and hs_d are registered every clk.
- Counters:
  - x counts pixels in the line, 0..H_PIXELS.
  - y counts lines, 0..V_LINES.
  - slot counts position in the byte, 0..3.
  - line_base holds the byte address of the current line start; it advances by H_PIXELS/4.
  - shift is an 8-bit accumulator.
- State WAIT_VS:
  - pix_evt and hs_fall are ignored.
  - On vs_fall with cap_en=1: x=y=slot=0, line_base=0, byte pointer=0, go to CAPTURE.
- State CAPTURE, pixel handling:
  - On pix_evt with x<H_PIXELS: the pixel is placed in slot, then slot++ and x++.
  - When slot==3, the completed byte is registered: the next cycle drives fb_we=1, fb_data=byte, fb_addr=pointer, and pointer then increments.
  - Latency: fb_we is high in the cycle after the clk edge at which pix_evt of the 4th pixel is true.
  - On pix_evt with x==H_PIXELS: pixel dropped, err=1.
- State CAPTURE, hs_fall:
  - x==0: ignored (blank line).
  - Otherwise, if x!=H_PIXELS: err=1. If slot!=0, the partial byte is written with the unfilled slots zero.
  - In all non-zero cases: y++, x=slot=0, line_base+=H_PIXELS/4, pointer=new line_base.
  - If the new y==V_LINES: frame_done=1 for one cycle, frame_cnt++, go to WAIT_VS.
- vs_fall in CAPTURE (frame restart):
  - If y!=0 or x!=0: err=1.
  - The frame restarts exactly as from WAIT_VS, using the current cap_en. No frame_done.
- Simultaneous events in one cycle:
  - hs_fall together with the 4th pix_evt: the pixel is processed first, then the line end. Exactly one full-byte write, no partial write.
  - vs_fall takes priority over hs_fall.
  - A flush write and a new full byte never collide: the 4-cycle packing guarantees at most one write per cycle.
- err:
  - Set has priority over err_clr in the same cycle.
  - cap_en deasserted mid-frame: the current frame completes normally, then the block stays in WAIT_VS.
- Reset mid-frame: immediate return to the reset state. No fb_we glitch.

Test Plan:
- Full 160x144 frame, all pixel=2'b10, clean sync:
  - 5760 fb_we pulses, fb_data=8'hAA, fb_addr 0..5759 contiguous.
  - frame_done once; frame_cnt=1; err=0.
- First line pixels 3,2,1,0:
  - fb_data=8'hE4 at fb_addr=0, fb_we exactly one clk after the 4th cpl rising edge is sampled.
- Line 0 with only 158 pixels, all 2'b11:
  - addr 39 gets 8'hF0; err=1.
  - Line 1's first byte goes to addr 40.
  - err_clr then clears err to 0.
- Pixels with valid=0, a held-high cpl (no new edge), and 161st pixel:
  - First two produce no capture.
  - The 161st is dropped with err=1 and no write beyond addr 39.
- cap_en=0 at vs_fall: no fb_we for the whole frame, busy=0. cap_en=1 at the next vs_fall: capture resumes at addr 0.
- rst low at line 70:
  - All outputs 0 immediately.
  - After release, nothing is written until the next vs_fall; the following frame gives frame_cnt=1.
